// File: rtl/urx_pkg.sv
// Shared definitions for the UART receive/transmit path: clocking constants,
// frame parser state encoding and rejection codes.
package urx_pkg;

   localparam int unsigned FCLK    = 50000000;
   localparam int unsigned COM_VEL = 115200;
   localparam int unsigned COM_NT  = FCLK / COM_VEL;

   // Frame parser states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LEN  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_CHK  = 2'd3;

   // Rejection causes reported on err_code
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_TO   = 2'd3;

   // Running frame checksum: XOR of LEN and payload bytes
   function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/urx_timeout_cnt.sv
// Inactivity counter shared by the UART receive and transmit paths.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart counting from zero this cycle (wins over terminal count)
//   en       : count while high; held at zero while low
//   tc_c     : combinational pulse on the cycle the count sits at TC-1
module urx_timeout_cnt #(
   parameter int unsigned TC = 8680
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CW = (TC > 2) ? $clog2(TC) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Terminal count only when no clear arrives in the same cycle
   assign tc_c = en && !clr && (cnt_q == CW'(TC - 1));

   // Next count
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || !en || tc_c) cnt_d = '0;
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/urx_frame_parser.sv
// Assembles SYNC/LEN/payload/CHK command frames from received UART bytes,
// checks length and XOR checksum, and holds the accepted payload for the
// command decoder.
//   clk, rst        : clock, synchronous active-high reset
//   rx_dat, rx_stb  : received byte and its one-cycle strobe
//   frame_ok        : pulse, frame accepted and buffer valid
//   frame_err       : pulse, frame rejected; err_code holds the cause
//   frame_len       : payload length of the last accepted frame
//   buf_valid       : buffer holds a complete accepted frame
//   busy            : parser is inside a frame
//   rd_addr, rd_dat : combinational payload read port (0 beyond frame_len)
module urx_frame_parser
   import urx_pkg::*;
#(
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned TO_CLKS = 8680,
   localparam int unsigned AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_dat,
   input  logic          rx_stb,
   output logic          frame_ok,
   output logic          frame_err,
   output logic [1:0]    err_code,
   output logic [7:0]    frame_len,
   output logic          buf_valid,
   output logic          busy,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_dat
);

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] chk_q, chk_d;
   logic       frame_ok_q, frame_ok_d;
   logic       frame_err_q, frame_err_d;
   logic [1:0] err_code_q, err_code_d;
   logic [7:0] frame_len_q, frame_len_d;
   logic       buf_valid_q, buf_valid_d;
   logic       busy_q, busy_d;
   logic [7:0] buf_q [MAX_LEN];
   logic [7:0] buf_d [MAX_LEN];
   logic       to_tc_c;

   // Inter-byte timeout: restarted by every byte, idle outside a frame
   urx_timeout_cnt #(.TC(TO_CLKS)) u_to (
      .clk  (clk),
      .rst  (rst),
      .clr  (rx_stb),
      .en   (state_q != S_IDLE),
      .tc_c (to_tc_c)
   );

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      chk_d       = chk_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      frame_len_d = frame_len_q;
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;

      case (state_q)
         S_IDLE: begin
            if (rx_stb && rx_dat == SYNC) begin
               state_d     = S_LEN;
               buf_valid_d = 1'b0;
            end
         end
         S_LEN: begin
            if (rx_stb) begin
               if (rx_dat != 8'd0 && rx_dat <= 8'(MAX_LEN)) begin
                  cnt_d   = rx_dat;
                  chk_d   = rx_dat;
                  idx_d   = 8'd0;
                  state_d = S_DATA;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_LEN;
                  state_d     = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (rx_stb) begin
               // Full-width index compare: nothing past MAX_LEN is ever written
               for (int unsigned i = 0; i < MAX_LEN; i++) begin
                  if (idx_q == 8'(i)) buf_d[i] = rx_dat;
               end
               chk_d = chk_step(chk_q, rx_dat);
               idx_d = idx_q + 8'd1;
               if (idx_q == cnt_q - 8'd1) state_d = S_CHK;
            end
         end
         default: begin
            if (rx_stb) begin
               if (rx_dat == chk_q) begin
                  frame_ok_d  = 1'b1;
                  frame_len_d = cnt_q;
                  buf_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
               state_d = S_IDLE;
            end
         end
      endcase

      // Timeout only fires on a cycle without a byte, so it never collides
      // with a byte-driven transition above
      if (to_tc_c) begin
         frame_err_d = 1'b1;
         err_code_d  = ERR_TO;
         state_d     = S_IDLE;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         idx_q       <= 8'd0;
         chk_q       <= 8'd0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         frame_len_q <= 8'd0;
         buf_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         for (int unsigned i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         chk_q       <= chk_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         frame_len_q <= frame_len_d;
         buf_valid_q <= buf_valid_d;
         busy_q      <= busy_d;
         for (int unsigned i = 0; i < MAX_LEN; i++) buf_q[i] <= buf_d[i];
      end
   end

   // Payload read port, zero beyond the accepted length
   always_comb begin
      rd_dat = 8'd0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (8'(rd_addr) == 8'(i) && 8'(i) < frame_len_q) rd_dat = buf_q[i];
      end
   end

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign frame_len = frame_len_q;
   assign buf_valid = buf_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_urx_frame_parser.sv
// Scoreboard bench for urx_frame_parser: frame outcomes are queued as each
// frame is driven and popped by a monitor when frame_ok/frame_err pulse.
module tb_urx_frame_parser;
   import urx_pkg::*;

   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned TO_CLKS = 8680;
   localparam int unsigned AW      = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_dat;
   logic          rx_stb;
   logic          frame_ok;
   logic          frame_err;
   logic [1:0]    err_code;
   logic [7:0]    frame_len;
   logic          buf_valid;
   logic          busy;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_dat;

   always #10 clk = ~clk;

   urx_frame_parser #(.SYNC(8'hA5), .MAX_LEN(MAX_LEN), .TO_CLKS(TO_CLKS)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_dat    (rx_dat),
      .rx_stb    (rx_stb),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .frame_len (frame_len),
      .buf_valid (buf_valid),
      .busy      (busy),
      .rd_addr   (rd_addr),
      .rd_dat    (rd_dat)
   );

   typedef struct {
      logic       ok;
      logic [1:0] code;
      logic [7:0] len;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [7:0] pl[$];
   logic [7:0] good_pl[$];
   int         total = 0;
   int         bad   = 0;
   logic       prev_pulse = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // One strobe cycle; consecutive calls give back-to-back strobes
   task automatic send_byte(input logic [7:0] b);
      rx_dat = b;
      rx_stb = 1'b1;
      @(posedge clk);
      #1;
      rx_stb = 1'b0;
      rx_dat = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_ok(input logic [7:0] len);
      exp_t e;
      e.ok = 1'b1; e.code = ERR_NONE; e.len = len;
      sb_q.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] code);
      exp_t e;
      e.ok = 1'b0; e.code = code; e.len = 8'h00;
      sb_q.push_back(e);
   endtask

   // Drives SYNC, LEN, payload from pl, then a correct or corrupted CHK
   task automatic send_frame(input logic bad_chk, input int gap);
      logic [7:0] c;
      c = 8'(pl.size());
      send_byte(8'hA5);
      send_byte(8'(pl.size()));
      foreach (pl[i]) begin
         send_byte(pl[i]);
         c = c ^ pl[i];
         idle(gap);
      end
      if (bad_chk) begin
         push_err(ERR_CHK);
         send_byte(c ^ 8'h03);
         check_eq("lat_err", 32'(frame_err), 32'd1);
      end else begin
         push_ok(8'(pl.size()));
         good_pl = pl;
         send_byte(c);
         check_eq("lat_ok", 32'(frame_ok), 32'd1);
      end
   endtask

   task automatic send_bad_len(input logic [7:0] len);
      send_byte(8'hA5);
      push_err(ERR_LEN);
      send_byte(len);
      check_eq("lat_len", 32'(frame_err), 32'd1);
      send_byte(8'h55);
      idle(2);
      check_eq("idle_ignore", 32'(busy), 32'd0);
   endtask

   task automatic verify_buf();
      logic [7:0] e;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         rd_addr = AW'(i);
         #1;
         e = (i < good_pl.size()) ? good_pl[i] : 8'h00;
         check_eq($sformatf("rd_dat[%0d]", i), 32'(rd_dat), 32'(e));
      end
      rd_addr = '0;
   endtask

   // Scoreboard monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         prev_pulse = 1'b0;
      end else begin
         if (frame_ok || frame_err) begin
            check_eq("pulse_gap", 32'(prev_pulse), 32'd0);
            if (sb_q.size() == 0) begin
               check_eq("unexp_evt", 32'({frame_ok, frame_err}), 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               check_eq("evt_ok", 32'(frame_ok), 32'(mon_e.ok));
               check_eq("evt_err", 32'(frame_err), 32'(!mon_e.ok));
               if (mon_e.ok) begin
                  check_eq("frame_len", 32'(frame_len), 32'(mon_e.len));
                  check_eq("buf_valid_ok", 32'(buf_valid), 32'd1);
               end else begin
                  check_eq("err_code", 32'(err_code), 32'(mon_e.code));
                  check_eq("buf_valid_err", 32'(buf_valid), 32'd0);
               end
            end
         end
         prev_pulse = frame_ok || frame_err;
      end
   end

   initial begin
      rst     = 1'b1;
      rx_stb  = 1'b0;
      rx_dat  = 8'h00;
      rd_addr = '0;
      idle(3);
      check_eq("rst_ok", 32'(frame_ok), 32'd0);
      check_eq("rst_err", 32'(frame_err), 32'd0);
      check_eq("rst_bv", 32'(buf_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_code", 32'(err_code), 32'd0);
      check_eq("rst_len", 32'(frame_len), 32'd0);
      check_eq("rst_rd", 32'(rd_dat), 32'd0);
      rst = 1'b0;
      idle(2);

      // Good frame
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(1'b0, 0);
      idle(1);
      verify_buf();

      // Bad checksum, then recovery with a gapped frame
      pl = '{8'h10, 8'h20};
      send_frame(1'b1, 0);
      idle(1);
      check_eq("chk_bv", 32'(buf_valid), 32'd0);
      check_eq("chk_code", 32'(err_code), 32'(ERR_CHK));
      pl = '{8'h7E};
      send_frame(1'b0, 2);
      idle(1);
      verify_buf();

      // Bad lengths
      send_bad_len(8'h00);
      send_bad_len(8'h11);

      // Maximum length frame
      pl = {};
      for (int i = 0; i < int'(MAX_LEN); i++) pl.push_back(8'(i * 3 + 1));
      send_frame(1'b0, 1);
      idle(1);
      verify_buf();

      // Timeout: error one cycle after the terminal cycle
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'hAA);
      push_err(ERR_TO);
      idle(TO_CLKS - 1);
      check_eq("to_early", 32'(frame_err), 32'd0);
      check_eq("to_busy_pre", 32'(busy), 32'd1);
      idle(1);
      check_eq("to_err", 32'(frame_err), 32'd1);
      check_eq("to_code", 32'(err_code), 32'(ERR_TO));
      check_eq("to_busy", 32'(busy), 32'd0);

      // Byte on the terminal cycle cancels the timeout
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'hAA);
      idle(TO_CLKS - 1);
      send_byte(8'hBB);
      check_eq("to_cancel", 32'(frame_err), 32'd0);
      check_eq("to_cancel_busy", 32'(busy), 32'd1);
      push_ok(8'd2);
      good_pl = '{8'hAA, 8'hBB};
      send_byte(8'h13);
      check_eq("to_cancel_ok", 32'(frame_ok), 32'd1);
      idle(1);
      verify_buf();

      // Noise before SYNC, SYNC value inside the payload
      send_byte(8'h00);
      idle(1);
      send_byte(8'hFF);
      send_byte(8'h5A);
      idle(1);
      check_eq("noise_busy", 32'(busy), 32'd0);
      pl = '{8'hA5, 8'h01, 8'hA5, 8'h02};
      send_frame(1'b0, 0);
      idle(1);
      verify_buf();

      // Reset mid-frame
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h01);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_bv", 32'(buf_valid), 32'd0);
      check_eq("mrst_err", 32'(frame_err), 32'd0);
      check_eq("mrst_code", 32'(err_code), 32'd0);
      check_eq("mrst_len", 32'(frame_len), 32'd0);
      idle(2);
      pl = '{8'hC3, 8'h3C};
      send_frame(1'b0, 0);
      idle(1);
      verify_buf();

      idle(5);
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/urx_frame_parser.md
Name: urx_frame_parser

Overview:
- Consumes the byte stream of the UART receive stage (`ok_rx_byte` strobe plus `sr_dat` byte).
- Assembles command frames of the form: SYNC, LEN, LEN payload bytes, CHK.
- Verifies length and checksum; holds the accepted payload in a small register buffer for the command decoder.
- Aborts on an inter-byte timeout and flags every failure with an error code.

Parameters:
- SYNC, 8'hA5, frame start byte.
- MAX_LEN, 16, maximum payload length in bytes (1..255).
- TO_CLKS, 8680, inter-byte timeout in clk cycles (two byte times at 50 MHz / 115200 baud).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_dat  in  8  received byte; valid only while rx_stb=1.
- rx_stb  in  1  one-cycle strobe per received byte (connected to ok_rx_byte); may repeat on consecutive cycles.
- frame_ok  out  1  one-cycle pulse: frame accepted, buffer valid.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  2  cause of last rejection: 1 bad LEN, 2 checksum mismatch, 3 timeout; held until next frame_err.
- frame_len  out  8  payload length of last accepted frame.
- buf_valid  out  1  buffer holds a complete accepted frame.
- busy  out  1  parser is inside a frame (state != IDLE).
- rd_addr  in  clog2(MAX_LEN)  payload read index.
- rd_dat  out  8  combinational payload byte at rd_addr; 0 when rd_addr >= frame_len.

Behaviour:
- Reset values: frame_ok, frame_err, buf_valid, busy = 0; err_code = 0; frame_len = 0; buffer = 0; state IDLE; timeout counter 0.
- All state advances only on cycles with rx_stb=1, except the timeout path.
- State IDLE:
  - rx_stb with rx_dat==SYNC -> LEN; clear buf_valid.
  - Any other byte is ignored silently.
- State LEN:
  - rx_dat in 1..MAX_LEN -> latch count, chk_acc = rx_dat, index = 0, go to DATA.
  - rx_dat of 0 or > MAX_LEN -> frame_err with err_code=1, go to IDLE.
- State DATA:
  - Each byte is written to buf[index]; chk_acc ^= rx_dat; index++.
  - After the LEN-th byte -> CHK.
  - SYNC values inside the payload are plain data.
- State CHK:
  - rx_dat == chk_acc -> frame_ok, frame_len = count, buf_valid=1.
  - Otherwise frame_err with err_code=2.
  - Either way, go to IDLE.
- Checksum: 8-bit XOR of the LEN byte and all payload bytes; SYNC is excluded.
- Output latency: frame_ok / frame_err assert the cycle after the rx_stb carrying CHK (or the bad LEN byte).
- Timeout:
  - The counter runs while state != IDLE and is cleared on every rx_stb.
  - When it reaches TO_CLKS-1 with no rx_stb that cycle: frame_err, err_code=3, go to IDLE.
  - If rx_stb and the timeout coincide, the byte wins: no error, counter cleared.
- Buffer contents during reception:
  - Bytes are written into the buffer as they arrive, so a rejected frame leaves buf_valid=0 with undefined contents.
  - rd_dat is meaningful only while buf_valid=1.
- frame_ok and frame_err are mutually exclusive and never assert on consecutive cycles from one frame.
- rst mid-frame: returns to IDLE next edge; all outputs take their reset values; no error pulse is emitted.
- Widths:
  - index and count are 8-bit.
  - Address compares are done at full width, so there is no wrap-around into the buffer.

Decomposition:
- Shared package `urx_pkg`:
  - Constants FCLK=50000000, COM_VEL=115200, COM_NT=FCLK/COM_VEL.
  - State encoding (IDLE, LEN, DATA, CHK).
  - Error codes ERR_NONE=0, ERR_LEN=1, ERR_CHK=2, ERR_TO=3.
- One natural sub-module: `urx_timeout_cnt` (clear, enable, terminal-count pulse), reused by the transmit side.
- The payload buffer stays inline as a register array.

Test Plan:
- Good frame: A5 03 11 22 33 03 -> frame_ok 1 cycle after CHK strobe; frame_len=3; buf_valid=1; rd_addr 0/1/2 -> 11/22/33; rd_addr 3 -> 00.
- Bad checksum: A5 02 10 20 31 (expected 32) -> frame_err, err_code=2, buf_valid=0; a following good frame A5 01 7E 7F gives frame_ok.
- Bad length:
  - A5 00 -> frame_err, err_code=1.
  - A5 11 (17 > MAX_LEN) -> err_code=1.
  - In both cases a subsequent byte 55 is ignored in IDLE.
- Timeout:
  - A5 02 AA, then no strobe for TO_CLKS cycles -> frame_err, err_code=3, busy=0.
  - A byte arriving exactly on the terminal cycle cancels the timeout.
- Noise and back-to-back:
  - Junk 00 FF 5A before A5; payload containing A5 is treated as data.
  - rx_stb on consecutive cycles -> all bytes captured, correct frame_ok.
- Reset mid-frame: rst asserted after A5 02 01 -> no error pulse, busy=0, buf_valid=0; next full frame accepted.
